// File: rtl/reg_dest_scoreboard.sv
// ---------------------------------------------------------------------------------------------
// reg_dest_scoreboard
//
// Tracks in-flight register writes between issue and writeback. Every issued destination
// register number is decoded into one of 32 per-register pending-write counters, and the
// matching counter is decremented when that write retires. A decode-stage source register
// whose counter is non-zero raises a stall.
//
// Register 0 is hard-wired to zero. Issues or writebacks that target it are ignored, and it
// never reports busy.
//
// Parameters
//   CNT_W        width of each pending-write counter (max in-flight per register = 2^CNT_W-1)
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high; clears all counters and err
//   issue_valid  an instruction that writes a register issues this cycle
//   issue_dest   destination register of the issuing instruction
//   wb_valid     writeback commits a register write this cycle
//   wb_dest      destination register being written back
//   src_a        decode-stage source register A
//   src_b        decode-stage source register B
//   stall        a source register has a pending write (combinational)
//   busy_vec     bit r set when counter r is non-zero (registered state, bit 0 always 0)
//   err          sticky overflow/underflow flag, cleared only by reset
//
// Configuration
//   SCOREBOARD_WB_BYPASS_EN  when defined, a source whose last pending write is being written
//                            back this cycle (and is not re-issued this cycle) does not stall.
//                            This models a register file that writes before it reads. busy_vec
//                            always reflects the raw counters.
// ---------------------------------------------------------------------------------------------
module reg_dest_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dest,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dest,
  input  logic [4:0]  src_a,
  input  logic [4:0]  src_b,
  output logic        stall,
  output logic [31:0] busy_vec,
  output logic        err
);

  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntZero = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [CNT_W-1:0] count_q [32];
  logic [CNT_W-1:0] count_d [32];
  logic             err_q;
  logic             err_d;

  // One-hot decode of the issue and writeback destinations. Bit 0 is masked so that
  // register 0 is never counted and never flags an error.
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_valid) begin
      inc_vec = 32'd1 << issue_dest;
    end
    if (wb_valid) begin
      dec_vec = 32'd1 << wb_dest;
    end
    inc_vec[0] = 1'b0;
    dec_vec[0] = 1'b0;
  end

  // Counter next-state. A simultaneous issue and writeback to the same register cancel.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < 32; r++) begin
      count_d[r] = count_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        if (count_q[r] == CntMax) begin
          err_d = 1'b1;
        end else begin
          count_d[r] = count_q[r] + CntOne;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (count_q[r] == CntZero) begin
          err_d = 1'b1;
        end else begin
          count_d[r] = count_q[r] - CntOne;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        count_q[r] <= CntZero;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        count_q[r] <= count_d[r];
      end
      err_q <= err_d;
    end
  end

  // Counter 0 never leaves zero, so busy_vec[0] is always 0.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < 32; r++) begin
      busy_vec[r] = (count_q[r] != CntZero);
    end
  end

  // Per-source write-before-read relief: the only outstanding write is retiring now and no
  // new write to the same register is issuing in this cycle.
  logic bypass_a;
  logic bypass_b;

`ifdef SCOREBOARD_WB_BYPASS_EN
  always_comb begin
    bypass_a = wb_valid && (wb_dest == src_a) && (count_q[src_a] == CntOne) &&
               !(issue_valid && (issue_dest == src_a));
    bypass_b = wb_valid && (wb_dest == src_b) && (count_q[src_b] == CntOne) &&
               !(issue_valid && (issue_dest == src_b));
  end
`else
  always_comb begin
    bypass_a = 1'b0;
    bypass_b = 1'b0;
  end
`endif

  logic stall_a;
  logic stall_b;

  always_comb begin
    stall_a = (src_a != 5'd0) && busy_vec[src_a] && !bypass_a;
    stall_b = (src_b != 5'd0) && busy_vec[src_b] && !bypass_b;
    stall   = stall_a || stall_b;
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
module tb_reg_dest_scoreboard;

  localparam int CntW   = 2;
  localparam int CntMax = (1 << CntW) - 1;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [4:0]  src_a;
  logic [4:0]  src_b;
  logic        stall;
  logic [31:0] busy_vec;
  logic        err;

  reg_dest_scoreboard #(
    .CNT_W (CntW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int m_cnt [32];
  bit m_err;

  typedef struct {
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic bit model_src_busy(input logic [4:0] s, input bit iv, input logic [4:0] id,
                                        input bit wv, input logic [4:0] wd);
    bit busy;
    busy = (s != 5'd0) && (m_cnt[s] != 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wv && wd == s && m_cnt[s] == 1 && !(iv && id == s)) busy = 1'b0;
`endif
    return busy;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge(input bit iv, input logic [4:0] id, input bit wv, input logic [4:0] wd);
    bit inc;
    bit dec;
    for (int r = 1; r < 32; r++) begin
      inc = iv && (id == r[4:0]);
      dec = wv && (wd == r[4:0]);
      if (inc && !dec) begin
        if (m_cnt[r] == CntMax) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] + 1;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else m_cnt[r] = m_cnt[r] - 1;
      end
    end
  endtask

  // One clock of stimulus: check combinational stall before the edge, queue the expected
  // post-edge state, then pop and compare after the edge.
  task automatic step(input string tag, input bit iv, input logic [4:0] id, input bit wv,
                      input logic [4:0] wd, input logic [4:0] sa, input logic [4:0] sb);
    exp_t e;
    bit exp_stall;
    issue_valid = iv;
    issue_dest  = id;
    wb_valid    = wv;
    wb_dest     = wd;
    src_a       = sa;
    src_b       = sb;
    #1;
    exp_stall = model_src_busy(sa, iv, id, wv, wd) || model_src_busy(sb, iv, id, wv, wd);
    check({tag, ".stall_pre"}, {31'd0, stall}, {31'd0, exp_stall});
    model_edge(iv, id, wv, wd);
    e.busy = model_busy();
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s.queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".busy"}, busy_vec, e.busy);
      check({tag, ".err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear before the next edge.
  task automatic async_reset(input string tag, input logic [4:0] sa, input logic [4:0] sb);
    src_a = sa;
    src_b = sb;
    issue_valid = 1'b0;
    wb_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    exp_q.delete();
    check({tag, ".busy"}, busy_vec, 32'd0);
    check({tag, ".err"}, {31'd0, err}, 32'd0);
    check({tag, ".stall"}, {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0;
    issue_dest = '0;
    wb_valid = 1'b0;
    wb_dest = '0;
    src_a = '0;
    src_b = '0;
    model_clear();
    #3;
    check("por.busy", busy_vec, 32'd0);
    check("por.err", {31'd0, err}, 32'd0);
    check("por.stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Issue r5, observe busy, retire at the third edge
    step("iss5", 1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd0);
    step("hold5", 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);
    step("wb5", 1'b0, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0);
    step("idle5", 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);

    // Register 0 is ignored in every role
    for (int i = 0; i < 3; i++) begin
      step("reg0", 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    end
    step("reg0.wbonly", 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);

    // Same-cycle issue/wb on r9 cancels; underflow sets err
    step("iss9", 1'b1, 5'd9, 1'b0, 5'd0, 5'd0, 5'd9);
    step("same9", 1'b1, 5'd9, 1'b1, 5'd9, 5'd0, 5'd9);
    step("wb9", 1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    step("under9", 1'b0, 5'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    step("after_err", 1'b1, 5'd12, 1'b0, 5'd0, 5'd12, 5'd0);
    step("wb12", 1'b0, 5'd0, 1'b1, 5'd12, 5'd12, 5'd0);

    async_reset("rst1", 5'd9, 5'd12);

    // Saturation on r7
    for (int i = 0; i < 4; i++) begin
      step("iss7", 1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 5'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step("wb7", 1'b0, 5'd0, 1'b1, 5'd7, 5'd0, 5'd7);
    end

    async_reset("rst2", 5'd0, 5'd0);

    // Write-before-read relief on r4 (config dependent)
    step("iss4", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0);
    step("wb4", 1'b0, 5'd0, 1'b1, 5'd4, 5'd0, 5'd4);
    // Retire with re-issue: never relieved
    step("iss4b", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0);
    step("wbiss4", 1'b1, 5'd4, 1'b1, 5'd4, 5'd4, 5'd0);
    // Two pending: retiring one still stalls
    step("iss4c", 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0);
    step("wb4two", 1'b0, 5'd0, 1'b1, 5'd4, 5'd4, 5'd0);
    step("wb4last", 1'b0, 5'd0, 1'b1, 5'd4, 5'd4, 5'd4);

    // Mid-run reset with count[5]=2 and err=1
    step("pre.iss5a", 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    step("pre.iss5b", 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0);
    step("pre.under3", 1'b0, 5'd0, 1'b1, 5'd3, 5'd5, 5'd0);
    async_reset("rst_mid", 5'd5, 5'd5);
    step("post.idle", 1'b0, 5'd0, 1'b0, 5'd0, 5'd5, 5'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
